uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Serialises one parallel byte into an asynchronous UART frame: start bit, DBIT data bits LSB first, stop bit(s). Frame format is 8N1 by default.
- Bit timing comes from an external oversampling enable `s_tick`, a single-cycle pulse at 16x the baud rate produced by the baud-rate generator.
- Sits between the host/FIFO side (`tx_din`/`tx_start`/`tx_done_tick`) and the serial line pin `tx`.

Parameters:
- DBIT, 8, number of data bits per frame (5..9).
- OS_TICK, 16, `s_tick` pulses per start/data bit.
- SB_TICK, 16, `s_tick` pulses for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-high reset. Asserted when 1, despite the legacy name.
- s_tick  input  1  oversampling enable, one clk cycle wide.
- tx_din  input  DBIT  byte to transmit, sampled only when a frame is accepted.
- tx_start  input  1  request to start a frame, level-sampled.
- tx  output  1  serial line, registered, idles high.
- tx_done_tick  output  1  one-cycle pulse at end of stop period.

Behaviour:
- Reset (reset_n=1, any time, including mid-frame):
  - state=IDLE, tick counter s=0, bit counter n=0, shift register b=0.
  - tx=1, tx_done_tick=0.
  - Any frame in progress is abandoned; no done pulse is produced.
- Registers: state, s (width clog2(max(OS_TICK,SB_TICK))), n (clog2(DBIT)), b (DBIT bits), tx_reg.
  - `tx` is driven directly from tx_reg, with no combinational path to the pin.
- IDLE:
  - tx=1.
  - If tx_start=1 on a clk edge: b<=tx_din, s<=0, state<=START, and tx_reg<=0 on that same edge.
  - Latency from the tx_start sampling edge to tx low is 0 cycles; tx is low from the following cycle onward.
  - tx_start does not wait for `s_tick`.
- START:
  - tx=0.
  - On `s_tick`: if s==OS_TICK-1 then s<=0, n<=0, state<=DATA; else s<=s+1.
- DATA:
  - tx=b[0].
  - On `s_tick` with s==OS_TICK-1: s<=0, b<=b>>1.
    - If n==DBIT-1: state<=STOP.
    - Else n<=n+1.
  - Otherwise on `s_tick`: s<=s+1.
- STOP:
  - tx=1.
  - On `s_tick` with s==SB_TICK-1: state<=IDLE, tx_done_tick=1 for exactly that clk cycle.
  - Otherwise on `s_tick`: s<=s+1.
- Frame length: OS_TICK*(1+DBIT)+SB_TICK `s_tick` pulses. This is 160 with defaults.
- Counters advance only on clk edges where s_tick=1. Cycles without s_tick hold all state.
- tx_start while not IDLE is ignored, with no queuing.
  - tx_start asserted in the same cycle as tx_done_tick is also ignored, because state is still STOP.
  - The next frame starts at the earliest one cycle after done.
- tx_din changes after acceptance do not affect the frame in flight.
- tx_done_tick is never asserted outside the STOP→IDLE transition.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP}, 2 bits;
  - default constants UART_DBIT=8, UART_OS_TICK=16, UART_SB_TICK=16, shared with the receiver and baud generator.
- Single module with no sub-module. The baud/tick generator is a separate sibling block and is not instantiated here.

Test Plan:
- Reset: hold reset_n=1 for 3 cycles with tx_start=1, tx_din=8'hFF.
  - Required: tx=1, tx_done_tick=0 throughout; state stays IDLE after release.
- Single frame: tx_din=8'h55, 1-cycle tx_start pulse, s_tick every 4th clk.
  - Required: tx=0 for 16 ticks, then 1,0,1,0,1,0,1,0 each held 16 ticks, then 1 for 16 ticks.
  - Required: exactly one tx_done_tick, at tick 160.
- Data latch: send 8'hA5, change tx_din to 8'h00 one cycle after tx_start.
  - Required: line shows bits 1,0,1,0,0,1,0,1.
- Ignored start: pulse tx_start with 8'h3C mid-DATA of an 8'h81 frame.
  - Required: only the 8'h81 frame is sent; one done pulse.
- Back-to-back: hold tx_start=1 continuously with tx_din=8'h0F.
  - Required: consecutive frames with exactly one clk of IDLE (tx=1) between stop end and next start bit; one done pulse per frame.
- Reset mid-frame: assert reset_n=1 during bit 3 of 8'h00.
  - Required: tx=1 immediately (asynchronous), no done pulse; a new 8'hC3 frame after release transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and the default frame format
// used by the transmitter, receiver and baud generator.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int UART_DBIT    = 8;
    localparam int UART_OS_TICK = 16;
    localparam int UART_SB_TICK = 16;

    // Counter width able to hold 0..max(a,b)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Host-side byte handshake of the UART transmitter: data, start request and
// end-of-frame pulse.
interface uart_transmitter_if
    import uart_pkg::*;
#(
    parameter int DBIT = UART_DBIT
) ();

    logic [DBIT-1:0] tx_din;
    logic            tx_start;
    logic            tx_done_tick;

    modport master (output tx_din, output tx_start, input tx_done_tick);
    modport slave  (input tx_din, input tx_start, output tx_done_tick);

endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one byte as start bit, DBIT data bits LSB first
// and a stop period, timed by a 16x oversampling tick from the baud generator.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DBIT    = UART_DBIT,
    parameter int OS_TICK = UART_OS_TICK,
    parameter int SB_TICK = UART_SB_TICK
) (
    input  logic                clk,
    input  logic                reset_n,   // active-high despite the name
    input  logic                s_tick,
    uart_transmitter_if.slave   host,
    output logic                tx
);

    localparam int S_W = cnt_width(OS_TICK, SB_TICK);
    localparam int N_W = cnt_width(DBIT, 1);

    localparam logic [S_W-1:0] OS_LAST = S_W'(OS_TICK - 1);
    localparam logic [S_W-1:0] SB_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST  = N_W'(DBIT - 1);

    state_t          r_state, w_state_next;
    logic [S_W-1:0]  r_s, w_s_next;
    logic [N_W-1:0]  r_n, w_n_next;
    logic [DBIT-1:0] r_b, w_b_next;
    logic            r_tx, w_tx_next;
    logic            w_done;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_tx    <= w_tx_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_done       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (host.tx_start) begin
                    w_state_next = START;
                    w_s_next     = '0;
                    w_b_next     = host.tx_din;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s == OS_LAST) begin
                        w_state_next = DATA;
                        w_s_next     = '0;
                        w_n_next     = '0;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s == OS_LAST) begin
                        w_s_next = '0;
                        w_b_next = r_b >> 1;
                        if (r_n == N_LAST) begin
                            w_state_next = STOP;
                        end else begin
                            w_n_next = r_n + 1'b1;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (r_s == SB_LAST) begin
                        w_state_next = IDLE;
                        w_done       = 1'b1;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Line level follows the state being entered, so the pin is registered
        // yet changes on the same edge as the state.
        unique case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_b_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    assign tx                = r_tx;
    assign host.tx_done_tick = w_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: stimulus queues expected bytes, a line
// monitor decodes frames tick by tick and compares them against the queue.
module tb_uart_transmitter;

    localparam int DBIT        = 8;
    localparam int OS          = 16;
    localparam int FRAME_TICKS = 160;

    logic clk = 1'b0;
    logic rst;
    logic s_tick = 1'b0;
    logic tx;

    uart_transmitter_if #(.DBIT(DBIT)) bus ();

    uart_transmitter #(.DBIT(DBIT), .OS_TICK(16), .SB_TICK(16)) dut (
        .clk     (clk),
        .reset_n (rst),
        .s_tick  (s_tick),
        .host    (bus),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int frames_seen = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
        end
    endtask

    // s_tick: one pulse every 4th clock
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            s_tick = (cnt == 3);
            cnt = (cnt + 1) % 4;
        end
    end

    // Line monitor and scoreboard
    initial begin
        bit in_frame;
        int ticks;
        int pos;
        int slot;
        logic [7:0] frame_byte;
        in_frame = 0;
        ticks = 0;
        frame_byte = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 0;
                check("reset_tx_high", tx, 1);
                check("reset_no_done", bus.tx_done_tick, 0);
            end else begin
                if (!in_frame && tx == 1'b0) begin
                    in_frame = 1;
                    ticks = 0;
                end
                if (!in_frame) begin
                    if (s_tick) check("idle_no_done", bus.tx_done_tick, 0);
                end else if (s_tick) begin
                    ticks++;
                    pos = (ticks - 1) % OS;
                    slot = (ticks - 1) / OS;
                    if (slot == 0) begin
                        check("start_bit", tx, 0);
                    end else if (slot <= DBIT) begin
                        if (pos == 0) frame_byte[slot-1] = tx;
                        else check("data_bit_stable", tx, frame_byte[slot-1]);
                    end else begin
                        check("stop_bit", tx, 1);
                    end
                    check("done_position", bus.tx_done_tick, (ticks == FRAME_TICKS));
                    if (ticks == FRAME_TICKS) begin
                        in_frame = 0;
                        frames_seen++;
                        if (exp_q.size() == 0) check("unexpected_frame", {24'h0, frame_byte}, 32'hFFFF_FFFF);
                        else check("frame_byte", frame_byte, exp_q.pop_front());
                    end
                end else begin
                    check("done_off_tick", bus.tx_done_tick, 0);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit expect_frame, input bit scramble);
        @(posedge clk);
        #1;
        bus.tx_din = d;
        bus.tx_start = 1'b1;
        if (expect_frame) exp_q.push_back(d);
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
        if (scramble) bus.tx_din = 8'h00;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (bus.tx_done_tick) seen = 1;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.tx_start = 1'b1;
        bus.tx_din = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_tx", tx, 1);
            check("rst_hold_done", bus.tx_done_tick, 0);
        end
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
        bus.tx_din = 8'h00;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle_after_reset", tx, 1);
        end

        // Single frame 0x55
        send(8'h55, 1, 0);
        wait_done();
        @(posedge clk);
        check("frames_after_55", frames_seen, 1);

        // Input byte is latched at acceptance
        send(8'hA5, 1, 1);
        wait_done();
        @(posedge clk);
        check("frames_after_A5", frames_seen, 2);

        // Start request during DATA of 0x81 is ignored
        send(8'h81, 1, 0);
        repeat (200) @(posedge clk);
        send(8'h3C, 0, 0);
        wait_done();
        repeat (700) @(posedge clk);
        check("frames_after_ignored", frames_seen, 3);
        check("idle_after_ignored", tx, 1);

        // Back-to-back frames with tx_start held high
        @(posedge clk);
        #1;
        bus.tx_din = 8'h0F;
        bus.tx_start = 1'b1;
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'h0F);
        wait_done();
        @(negedge clk);
        check("b2b_idle_gap", tx, 1);
        @(negedge clk);
        check("b2b_next_start", tx, 0);
        wait_done();
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
        wait_done();
        repeat (8) @(posedge clk);
        check("frames_after_b2b", frames_seen, 6);
        check("idle_after_b2b", tx, 1);

        // Asynchronous reset during data bit 3 of 0x00
        send(8'h00, 0, 0);
        repeat (288) @(posedge clk);
        check("pre_reset_tx_low", tx, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_tx", tx, 1);
        check("async_reset_done", bus.tx_done_tick, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'hC3, 1, 0);
        wait_done();
        @(posedge clk);
        check("frames_after_reset", frames_seen, 7);

        repeat (4) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
